// File: rtl/fir_ntap_stream.sv
// N-tap streaming FIR filter: delay line, product stage, sum stage, then scale and saturate.
// Build option FIR_APPROX_ADD_EN replaces every sum-chain adder with a lower-part-OR adder.
module fir_ntap_stream #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int TAPS       = 8,
  parameter int OUT_SHIFT  = 15,
  parameter int APPROX_LSB = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   x,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   y,
  output logic                       sat,
  output logic                       coef_busy
);
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam logic signed [ACC_W-1:0] T_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] T_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (TAPS < 2) begin : g_bad_taps
    $error("fir_ntap_stream: TAPS must be at least 2");
  end
  if (APPROX_LSB < 1 || APPROX_LSB >= ACC_W) begin : g_bad_lsb
    $error("fir_ntap_stream: APPROX_LSB out of range");
  end

  logic signed [DATA_W-1:0] d_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [PROD_W-1:0] p_q [TAPS];
  logic signed [ACC_W-1:0]  s_q, sum_d, t_w;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     sat_q, sat_d;
  logic                     dv_q, pv_q, sv_q, ov_q, busy_q;
  logic                     addr_ok, wr_en;

`ifdef FIR_APPROX_ADD_EN
  function automatic logic signed [ACC_W-1:0] chain_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
    logic [ACC_W-APPROX_LSB-1:0] hi;
    logic                        cin;
    cin = a[APPROX_LSB-1] & b[APPROX_LSB-1];
    hi  = a[ACC_W-1:APPROX_LSB] + b[ACC_W-1:APPROX_LSB] + {{(ACC_W-APPROX_LSB-1){1'b0}}, cin};
    return {hi, a[APPROX_LSB-1:0] | b[APPROX_LSB-1:0]};
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] chain_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction
`endif

  if ((1 << AW) == TAPS) begin : g_addr_pow2
    assign addr_ok = 1'b1;
  end else begin : g_addr_range
    assign addr_ok = (32'(coef_addr) < TAPS);
  end

  // Writes only land while no sample sits in the delay line, product or sum stage.
  assign wr_en = coef_we & ~busy_q & ~in_valid & addr_ok;

  always_comb begin
    sum_d = {{AW{p_q[0][PROD_W-1]}}, p_q[0]};
    for (int i = 1; i < TAPS; i++) begin
      sum_d = chain_add(sum_d, {{AW{p_q[i][PROD_W-1]}}, p_q[i]});
    end
  end

  always_comb begin
    t_w   = s_q >>> OUT_SHIFT;
    y_d   = t_w[DATA_W-1:0];
    sat_d = 1'b0;
    if (t_w > T_MAX) begin
      y_d   = {1'b0, {(DATA_W-1){1'b1}}};
      sat_d = 1'b1;
    end else if (t_w < T_MIN) begin
      y_d   = {1'b1, {(DATA_W-1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < TAPS; i++) begin
        d_q[i] <= '0;
        c_q[i] <= '0;
        p_q[i] <= '0;
      end
      s_q    <= '0;
      y_q    <= '0;
      sat_q  <= 1'b0;
      dv_q   <= 1'b0;
      pv_q   <= 1'b0;
      sv_q   <= 1'b0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (in_valid) begin
        d_q[0] <= x;
        for (int i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
      end
      if (wr_en) c_q[coef_addr] <= coef_data;
      if (dv_q) begin
        for (int i = 0; i < TAPS; i++) p_q[i] <= d_q[i] * c_q[i];
      end
      if (pv_q) s_q <= sum_d;
      if (sv_q) begin
        y_q   <= y_d;
        sat_q <= sat_d;
      end
      dv_q   <= in_valid;
      pv_q   <= dv_q;
      sv_q   <= pv_q;
      ov_q   <= sv_q;
      busy_q <= in_valid | dv_q | pv_q;
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
  assign sat       = sat_q;
  assign coef_busy = busy_q;
endmodule

// File: tb/tb_fir_ntap_stream.sv
// Bench for fir_ntap_stream: directed phases plus random traffic against an arithmetic reference model.
module tb_fir_ntap_stream;
  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int TAPS       = 8;
  localparam int OUT_SHIFT  = 15;
  localparam int APPROX_LSB = 4;
  localparam int AW         = $clog2(TAPS);
  localparam longint YMAX   = (longint'(1) <<< (DATA_W-1)) - 1;
  localparam longint YMIN   = -(longint'(1) <<< (DATA_W-1));

  // clock / reset
  logic clk = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] x = '0;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     out_valid, sat, coef_busy;
  logic signed [DATA_W-1:0] y;

  fir_ntap_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
    .OUT_SHIFT(OUT_SHIFT), .APPROX_LSB(APPROX_LSB)
  ) dut (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .y(y), .sat(sat), .coef_busy(coef_busy)
  );

  // scoreboard and reference model state
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W:0] exp_q[$];
  int acc_q[$];
  longint hist[TAPS];
  longint coef[TAPS];
  int edge_n;
  int last_acc;
  bit m_ov, m_sat, m_busy;
  longint m_y;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic longint model_add(input longint a, input longint b);
`ifdef FIR_APPROX_ADD_EN
    longint m, lo, c;
    m  = longint'(1) << APPROX_LSB;
    lo = (a | b) & (m - 1);
    c  = (a >>> (APPROX_LSB-1)) & (b >>> (APPROX_LSB-1)) & 1;
    return ((a >>> APPROX_LSB) + (b >>> APPROX_LSB) + c) * m + lo;
`else
    return a + b;
`endif
  endfunction

  // Dot product of history and coefficients, floor-shifted and clipped.
  function automatic logic [DATA_W:0] model_result();
    longint s, t;
    s = hist[0] * coef[0];
    for (int i = 1; i < TAPS; i++) s = model_add(s, hist[i] * coef[i]);
    t = s >>> OUT_SHIFT;
    if (t > YMAX) return {1'b1, DATA_W'(YMAX)};
    if (t < YMIN) return {1'b1, DATA_W'(YMIN)};
    return {1'b0, DATA_W'(t)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      coef[i] = 0;
    end
    exp_q.delete();
    acc_q.delete();
    edge_n = 0;
    last_acc = -100;
    m_ov = 1'b0;
    m_sat = 1'b0;
    m_busy = 1'b0;
    m_y = 0;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_edge(input bit v, input longint xv, input bit we, input int addr,
                            input longint data);
    bit wr_ok;
    logic signed [COEF_W-1:0] cd;
    logic [DATA_W:0] r;
    wr_ok = we && !m_busy && !v && (addr < TAPS);
    edge_n++;
    if (acc_q.size() > 0 && acc_q[0] == edge_n - 3) begin
      void'(acc_q.pop_front());
      r = exp_q.pop_front();
      m_ov = 1'b1;
      m_sat = r[DATA_W];
      m_y = longint'($signed(r[DATA_W-1:0]));
    end else begin
      m_ov = 1'b0;
    end
    if (v) begin
      for (int i = TAPS-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = xv;
      exp_q.push_back(model_result());
      acc_q.push_back(edge_n);
      last_acc = edge_n;
    end
    m_busy = (edge_n - last_acc) < 3;
    if (wr_ok) begin
      cd = data[COEF_W-1:0];
      coef[addr] = longint'(cd);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", longint'(out_valid), longint'(m_ov));
    check("y", longint'(y), m_y);
    check("sat", longint'(sat), longint'(m_sat));
    check("coef_busy", longint'(coef_busy), longint'(m_busy));
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic cycle(input bit v, input longint xv, input bit we, input int addr,
                       input longint data);
    in_valid = v;
    x = DATA_W'(xv);
    coef_we = we;
    coef_addr = AW'(addr);
    coef_data = COEF_W'(data);
    model_edge(v, xv, we, addr, data);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rstN = 1'b0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
    rstN = 1'b1;
  endtask

  task automatic load_coef(input int addr, input longint data);
    cycle(1'b0, 0, 1'b1, addr, data);
  endtask

  task automatic impulse(input longint amp);
    cycle(1'b1, amp, 1'b0, 0, 0);
    idle(10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset(10);

    // impulse response with ramp coefficients (top tap clipped to the coefficient range)
    for (int i = 0; i < TAPS; i++) load_coef(i, ((i + 1) * 4096 > 32767) ? 32767 : (i + 1) * 4096);
    impulse(16384);

    // saturation both ways
    for (int i = 0; i < TAPS; i++) load_coef(i, 32767);
    repeat (12) cycle(1'b1, 32767, 1'b0, 0, 0);
    repeat (12) cycle(1'b1, -32768, 1'b0, 0, 0);
    idle(5);

    // bubbles: alternating valid
    for (int i = 0; i < TAPS; i++) load_coef(i, (i % 2 == 0) ? 3000 : -2000);
    for (int n = 0; n < 20; n++) begin
      longint xv;
      xv = longint'($urandom_range(0, 65535)) - 32768;
      cycle(n % 2 == 0, xv, 1'b0, 0, 0);
    end
    idle(5);

    // coefficient lockout: writes during busy and alongside in_valid are dropped
    for (int i = 0; i < TAPS; i++) load_coef(i, 1000 * (i + 1));
    impulse(12000);
    cycle(1'b1, 12000, 1'b1, 2, -7777);
    cycle(1'b0, 0, 1'b1, 3, -7777);
    cycle(1'b0, 0, 1'b1, 4, -7777);
    cycle(1'b0, 0, 1'b1, 5, -7777);
    idle(6);
    impulse(12000);

    // random traffic with random coefficient write attempts
    for (int n = 0; n < 1500; n++) begin
      bit v, we;
      longint xv, cd;
      v = ($urandom_range(0, 9) < 6);
      we = ($urandom_range(0, 3) == 0);
      xv = longint'($urandom_range(0, 65535)) - 32768;
      if (n < 750) cd = longint'($urandom_range(0, 8191)) - 4096;
      else cd = longint'($urandom_range(0, 65535)) - 32768;
      cycle(v, xv, we, $urandom_range(0, TAPS-1), cd);
      if (n % 100 == 99) idle(4);
    end
    idle(5);

    // reset pulse mid-stream, then restart from zero history
    for (int i = 0; i < TAPS; i++) load_coef(i, 2500 + 300 * i);
    repeat (6) cycle(1'b1, 9000, 1'b0, 0, 0);
    do_reset(1);
    idle(2);
    for (int i = 0; i < TAPS; i++) load_coef(i, 2500 + 300 * i);
    repeat (10) cycle(1'b1, 9000, 1'b0, 0, 0);
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
